// File: rtl/booth_div_seq.sv
// Sequential signed restoring divider, 2N/N -> 2N quotient, N remainder.
// Define BOOTH_DIV_SAT_EN to saturate the quotient on divide-by-zero/overflow.
module booth_div_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0]  QMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  QMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [W-1:0]  qr;
    logic [N:0]    rem;
    logic [N-1:0]  dmag;
    logic          sd;
    logic          sv;
    logic          zr;
    logic          of;

    logic [N+1:0]  sh;
    logic [N:0]    diff;
    logic          ge;

    // Dividend bits leave qr at the MSB while quotient bits enter at the LSB.
    assign sh   = {rem, qr[W-1]};
    assign diff = sh[N:0] - {1'b0, dmag};
    assign ge   = sh >= {2'b0, dmag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            cnt       <= '0;
            qr        <= '0;
            rem       <= '0;
            dmag      <= '0;
            sd        <= 1'b0;
            sv        <= 1'b0;
            zr        <= 1'b0;
            of        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (start) begin
                        // W-bit unsigned magnitude is exact even for -2^(W-1).
                        qr   <= dividend[W-1] ? -dividend : dividend;
                        dmag <= divisor[N-1] ? -divisor : divisor;
                        sd   <= dividend[W-1];
                        sv   <= divisor[N-1];
                        zr   <= (divisor == '0);
                        of   <= (dividend == QMIN) && (divisor == '1);
                        rem  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                        st   <= CALC;
                    end
                end
                CALC: begin
                    qr  <= {qr[W-2:0], ge};
                    rem <= ge ? diff : sh[N:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) st <= FIX;
                end
                FIX: begin
                    if (zr) begin
`ifdef BOOTH_DIV_SAT_EN
                        qr <= sd ? QMIN : QMAX;
`else
                        qr <= '0;
`endif
                        rem <= '0;
                    end else if (of) begin
`ifdef BOOTH_DIV_SAT_EN
                        qr <= QMAX;
`else
                        qr <= QMIN;
`endif
                        rem <= '0;
                    end else begin
                        qr  <= (sd ^ sv) ? -qr : qr;
                        rem <= {1'b0, sd ? -rem[N-1:0] : rem[N-1:0]};
                    end
                    st <= DONE;
                end
                DONE: begin
                    quotient  <= qr;
                    remainder <= rem[N-1:0];
                    dbz       <= zr;
                    ovf       <= of;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div_seq.sv
// Directed self-checking bench for booth_div_seq (N=8).
// Expected saturated results follow BOOTH_DIV_SAT_EN when defined.
module tb_booth_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    booth_div_seq #(.N(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .dbz(dbz),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [31:0] o,
                       input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tg, o, e);
        end
    endtask

    task automatic run(input string tg, input logic [15:0] dd,
                       input logic [7:0] dv, input logic [15:0] eq,
                       input logic [7:0] er, input logic ez,
                       input logic eo);
        int n;
        bit seen;
        @(posedge clk); #1;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tg, ".busy"}, busy, 1);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        chk({tg, ".lat"}, n, 18);
        chk({tg, ".q"}, quotient, eq);
        chk({tg, ".r"}, remainder, er);
        chk({tg, ".dbz"}, dbz, ez);
        chk({tg, ".ovf"}, ovf, eo);
        chk({tg, ".nbusy"}, busy, 0);
    endtask

    initial begin
        int nd;
        int last;
        int t [3];
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.dbz", dbz, 0);
        chk("rst.ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("20/2", 16'd20, 8'd2, 16'd10, 8'd0, 0, 0);
        run("-8/4", 16'hFFF8, 8'd4, 16'hFFFE, 8'd0, 0, 0);
        run("-3120/20", 16'hF3D0, 8'd20, 16'hFF64, 8'd0, 0, 0);
        run("6000/-30", 16'd6000, 8'hE2, 16'hFF38, 8'd0, 0, 0);
        run("-560/-10", 16'hFDD0, 8'hF6, 16'd56, 8'd0, 0, 0);
        run("-7/2", 16'hFFF9, 8'd2, 16'hFFFD, 8'hFF, 0, 0);
        run("7/-2", 16'd7, 8'hFE, 16'hFFFD, 8'd1, 0, 0);
        run("-1/-128", 16'hFFFF, 8'h80, 16'd0, 8'hFF, 0, 0);
`ifdef BOOTH_DIV_SAT_EN
        run("100/0", 16'd100, 8'd0, 16'h7FFF, 8'd0, 1, 0);
        run("-100/0", 16'hFF9C, 8'd0, 16'h8000, 8'd0, 1, 0);
        run("min/-1", 16'h8000, 8'hFF, 16'h7FFF, 8'd0, 0, 1);
`else
        run("100/0", 16'd100, 8'd0, 16'd0, 8'd0, 1, 0);
        run("-100/0", 16'hFF9C, 8'd0, 16'd0, 8'd0, 1, 0);
        run("min/-1", 16'h8000, 8'hFF, 16'h8000, 8'd0, 0, 1);
`endif

        // extra starts while busy are ignored
        @(posedge clk); #1;
        dividend = 16'd1000;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        last = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3 || i == 10) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                nd++;
                last = i;
                chk("ign.q", quotient, 100);
                chk("ign.r", remainder, 0);
            end
        end
        chk("ign.ndone", nd, 1);
        chk("ign.when", last, 18);

        // start held high: one result every 19 cycles
        @(posedge clk); #1;
        dividend = 16'd1000;
        divisor  = 8'd10;
        start    = 1'b1;
        nd = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd < 3) t[nd] = e;
                nd++;
                chk("bb.q", quotient, 100);
            end
        end
        start = 1'b0;
        chk("bb.ndone", nd, 3);
        if (nd == 3) begin
            chk("bb.gap1", t[1] - t[0], 19);
            chk("bb.gap2", t[2] - t[1], 19);
        end
        repeat (25) @(posedge clk);
        #1;

        // asynchronous reset in the middle of CALC
        dividend = 16'd1000;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        chk("arst.q", quotient, 0);
        chk("arst.r", remainder, 0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("arst.nodone", nd, 0);
        run("50/7", 16'd50, 8'd7, 16'd7, 8'd1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
